// File: rtl/conv_1d_pkg.sv
// Shared types and helpers for the 1-D streaming convolution datapath.
package conv_1d_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  // Number of output columns produced by one run.
  function automatic int result_w(input int img_w, input int pad,
                                  input int filter_l, input int stride_w);
    return (img_w + 2 * pad - filter_l) / stride_w + 1;
  endfunction

endpackage

// File: rtl/conv_1d_stream_dpath_if.sv
// Image column stream in, result write port out.
interface conv_1d_stream_dpath_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_D      = 8,
  parameter int ACC_W      = 21,
  parameter int RES_AW     = 5
);
  logic                         img_valid;
  logic                         img_ready;
  logic [DATA_WIDTH*IMG_D-1:0]  img_data;
  logic                         result_wren;
  logic [RES_AW-1:0]            result_wraddr;
  logic signed [ACC_W-1:0]      result_wrdata;

  modport master (output img_valid, img_data,
                  input  img_ready, result_wren, result_wraddr, result_wrdata);
  modport slave  (input  img_valid, img_data,
                  output img_ready, result_wren, result_wraddr, result_wrdata);
endinterface

// File: rtl/conv_1d_dot_pipe.sv
// Pipelined N-element signed dot product: one multiply stage, then one
// registered adder level per stage of a binary tree. Valid and address
// travel alongside in a delay line of the same depth.
module conv_1d_dot_pipe #(
  parameter int N          = 24,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 5
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  input  logic [AW-1:0]                            in_addr,
  input  logic [DATA_WIDTH*N-1:0]                  a,
  input  logic [DATA_WIDTH*N-1:0]                  b,
  output logic                                     out_valid,
  output logic [AW-1:0]                            out_addr,
  output logic signed [2*DATA_WIDTH+$clog2(N)-1:0] out_data
);
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(N);
  localparam int LV    = $clog2(N);
  localparam int P     = 1 << LV;
  localparam int LAT   = LV + 1;

  // Heap-ordered tree: node 0 is the root, leaves sit at P-1 .. 2P-2.
  logic signed [ACC_W-1:0] node [2*P-1];
  logic signed [ACC_W-1:0] prod [P];
  logic [LAT:1]            vld_pipe;
  logic [AW-1:0]           addr_pipe [1:LAT];

  for (genvar i = 0; i < P; i++) begin : g_prod
    if (i < N) begin : g_real
      logic signed [ACC_W-1:0] ea, eb;
      assign ea      = ACC_W'($signed(a[i*DATA_WIDTH +: DATA_WIDTH]));
      assign eb      = ACC_W'($signed(b[i*DATA_WIDTH +: DATA_WIDTH]));
      assign prod[i] = ea * eb;
    end else begin : g_zero
      assign prod[i] = '0;
    end
  end

  // Multiply into the leaves, add one tree level per clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 2*P-1; n++) node[n] <= '0;
    end else begin
      for (int i = 0; i < P; i++)   node[P-1+i] <= prod[i];
      for (int n = 0; n < P-1; n++) node[n] <= node[2*n+1] + node[2*n+2];
    end
  end

  // Valid/address delay line matched to the arithmetic latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int k = 1; k <= LAT; k++) addr_pipe[k] <= '0;
    end else begin
      vld_pipe[1]  <= in_valid;
      addr_pipe[1] <= in_addr;
      for (int k = 2; k <= LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
    end
  end

  assign out_valid = vld_pipe[LAT];
  assign out_addr  = addr_pipe[LAT];
  assign out_data  = node[0];
endmodule

// File: rtl/conv_1d_stream_dpath.sv
// Streaming 1-D convolution: columns shift through a FILTER_L-deep window,
// strided windows are issued into the dot-product pipe, results are written
// out in order with their column index.
module conv_1d_stream_dpath
  import conv_1d_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_D      = 8,
  parameter int FILTER_L   = 3,
  parameter int STRIDE_W   = 1,
  parameter int PAD        = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [DATA_WIDTH*IMG_D*FILTER_L-1:0] fil,
  conv_1d_stream_dpath_if.slave                bus,
  output logic                                 busy,
  output logic                                 done
);
  localparam int N        = IMG_D * FILTER_L;
  localparam int TOT      = IMG_W + 2 * PAD;
  localparam int RESULT_W = result_w(IMG_W, PAD, FILTER_L, STRIDE_W);
  localparam int PIPE_LAT = $clog2(N) + 1;
  localparam int RES_AW   = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
  localparam int CW       = $clog2(TOT + 1);
  localparam int SW       = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;
  localparam int DCW      = $clog2(PIPE_LAT + 1);

  state_t                                   state, state_nx;
  logic [CW-1:0]                            col_idx;
  logic [SW-1:0]                            stride_cnt;
  logic [RES_AW-1:0]                        out_idx, issue_addr;
  logic [DCW-1:0]                           drain_cnt;
  logic [FILTER_L-1:0][IMG_D*DATA_WIDTH-1:0] win;
  logic [IMG_D*DATA_WIDTH-1:0]              col_in;
  logic                                     issue_vld, pad_col, shift;

  // Column source selection and handshake.
  always_comb begin
    pad_col       = (col_idx < CW'(PAD)) || (col_idx >= CW'(PAD + IMG_W));
    bus.img_ready = (state == STREAM) && !pad_col;
    shift         = (state == STREAM) && (pad_col || bus.img_valid);
    col_in        = pad_col ? '0 : bus.img_data;
    busy          = (state == STREAM) || (state == DRAIN);
    done          = (state == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state. DRAIN covers the issue cycle of the last window plus the
  // pipe latency, so DONE lands the cycle after the final write.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = STREAM;
      STREAM: if (shift && col_idx == CW'(TOT - 1)) state_nx = DRAIN;
      DRAIN:  if (drain_cnt == DCW'(PIPE_LAT)) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window shift, stride tracking and window issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_idx    <= '0;
      stride_cnt <= '0;
      out_idx    <= '0;
      issue_vld  <= 1'b0;
      issue_addr <= '0;
      drain_cnt  <= '0;
      win        <= '0;
    end else begin
      issue_vld <= 1'b0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (state == IDLE && start) begin
        col_idx    <= '0;
        stride_cnt <= '0;
        out_idx    <= '0;
      end
      if (shift) begin
        for (int t = 0; t < FILTER_L-1; t++) win[t] <= win[t+1];
        win[FILTER_L-1] <= col_in;
        col_idx         <= col_idx + CW'(1);
        // col_idx+1 columns now held; the first full window is at FILTER_L.
        if (col_idx >= CW'(FILTER_L - 1)) begin
          if (stride_cnt == '0) begin
            issue_vld  <= 1'b1;
            issue_addr <= out_idx;
            out_idx    <= out_idx + RES_AW'(1);
          end
          stride_cnt <= (stride_cnt == SW'(STRIDE_W - 1)) ? '0 : stride_cnt + SW'(1);
        end
      end
    end
  end

  conv_1d_dot_pipe #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (RES_AW)
  ) u_dot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue_vld),
    .in_addr   (issue_addr),
    .a         (win),
    .b         (fil),
    .out_valid (bus.result_wren),
    .out_addr  (bus.result_wraddr),
    .out_data  (bus.result_wrdata)
  );
endmodule
